mw_countdown_timer: RTL and testbench

MW_COUNTDOWN_TIMER -- requirements
Module: mw_countdown_timer

---
 rtl/mw_countdown_timer.sv | 210 +++++++++++++++++++++
 tb/tb_mw_countdown_timer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mw_countdown_timer.sv
// Countdown timer (MM:SS, up to 99:59) with a start/stop/pause command
// interface and a multiplexed, active-low 7-segment display driver.
module mw_countdown_timer #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    output logic       done,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED
    } state_t;

    state_t          r_state;
    logic   [6:0]    r_min;
    logic   [5:0]    r_sec;
    logic   [TW-1:0] r_presc;
    logic   [SW-1:0] r_scan_cnt;
    logic   [2:0]    r_slot;

    state_t          w_state_nxt;
    logic   [6:0]    w_min_nxt;
    logic   [5:0]    w_sec_nxt;
    logic   [TW-1:0] w_presc_nxt;
    logic   [SW-1:0] w_scan_nxt;
    logic   [2:0]    w_slot_nxt;
    logic            w_scan_wrap;

    logic   [6:0]    w_ld_min;
    logic   [5:0]    w_ld_sec;
    logic            w_ld_zero;

    logic   [3:0]    w_sec_units;
    logic   [3:0]    w_sec_tens;
    logic   [3:0]    w_min_units;
    logic   [3:0]    w_min_tens;
    logic   [7:0]    w_an_nxt;
    logic   [7:0]    w_cat_nxt;

    // Segment pattern for one decimal digit, dp off (bit 7 = a, bit 0 = dp)
    function automatic logic [7:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 8'h03;
            4'd1:    return 8'h9F;
            4'd2:    return 8'h25;
            4'd3:    return 8'h0D;
            4'd4:    return 8'h99;
            4'd5:    return 8'h49;
            4'd6:    return 8'h41;
            4'd7:    return 8'h1F;
            4'd8:    return 8'h01;
            4'd9:    return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    // Scan order skips slot 4: 0,1,2,3,5
    function automatic logic [2:0] f_next_slot(input logic [2:0] s);
        case (s)
            3'd0:    return 3'd1;
            3'd1:    return 3'd2;
            3'd2:    return 3'd3;
            3'd3:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    assign w_ld_min  = (min > 7'd99) ? 7'd99 : min;
    assign w_ld_sec  = (sec > 7'd59) ? 6'd59 : sec[5:0];
    assign w_ld_zero = (w_ld_min == 7'd0) && (w_ld_sec == 6'd0);

    // Next-state for the command FSM, remaining-time count and prescaler
    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_presc_nxt = r_presc;
        if (stop) begin
            w_state_nxt = IDLE;
            w_min_nxt   = '0;
            w_sec_nxt   = '0;
            w_presc_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !w_ld_zero) begin
                        w_state_nxt = RUN;
                        w_min_nxt   = w_ld_min;
                        w_sec_nxt   = w_ld_sec;
                        w_presc_nxt = '0;
                    end
                end
                RUN: begin
                    // The pause edge still counts as a running cycle, so a
                    // resumed countdown completes the interrupted second.
                    if (pause) begin
                        w_state_nxt = PAUSED;
                    end
                    if (r_presc == TW'(TICK_DIV - 1)) begin
                        w_presc_nxt = '0;
                        if (r_sec != 6'd0) begin
                            w_sec_nxt = r_sec - 6'd1;
                        end else if (r_min != 7'd0) begin
                            w_min_nxt = r_min - 7'd1;
                            w_sec_nxt = 6'd59;
                        end
                        if (r_min == 7'd0 && r_sec == 6'd1) begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_presc_nxt = r_presc + TW'(1);
                    end
                end
                PAUSED: begin
                    if (pause || start) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Next scan counter and digit slot
    always_comb begin
        w_scan_wrap = (r_scan_cnt == SW'(SCAN_DIV - 1));
        w_scan_nxt  = w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
        w_slot_nxt  = w_scan_wrap ? f_next_slot(r_slot) : r_slot;
    end

    assign w_sec_units = 4'(w_sec_nxt % 6'd10);
    assign w_sec_tens  = 4'(w_sec_nxt / 6'd10);
    assign w_min_units = 4'(w_min_nxt % 7'd10);
    assign w_min_tens  = 4'(w_min_nxt / 7'd10);

    // Display pattern from the next slot and next count, so the registered
    // outputs change on the same edge as the slot or count they show.
    always_comb begin
        w_an_nxt  = 8'hFF;
        w_cat_nxt = 8'hFF;
        case (w_slot_nxt)
            3'd0: begin
                w_an_nxt  = 8'b1111_1110;
                w_cat_nxt = f_seg(w_sec_units);
            end
            3'd1: begin
                w_an_nxt  = 8'b1111_1101;
                w_cat_nxt = f_seg(w_sec_tens);
            end
            3'd2: begin
                w_an_nxt  = 8'b1111_1011;
                w_cat_nxt = f_seg(w_min_units) & 8'hFE;
            end
            3'd3: begin
                w_an_nxt  = 8'b1111_0111;
                w_cat_nxt = f_seg(w_min_tens);
            end
            3'd5: begin
                w_an_nxt  = 8'b1101_1111;
                w_cat_nxt = 8'hFF;
            end
            default: begin
                w_an_nxt  = 8'hFF;
                w_cat_nxt = 8'hFF;
            end
        endcase
    end

    // State, count, prescaler, scan and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_min      <= '0;
            r_sec      <= '0;
            r_presc    <= '0;
            r_scan_cnt <= '0;
            r_slot     <= 3'd0;
            done       <= 1'b1;
            an         <= 8'b1111_1110;
            dec_cat    <= 8'h03;
        end else begin
            r_state    <= w_state_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_presc    <= w_presc_nxt;
            r_scan_cnt <= w_scan_nxt;
            r_slot     <= w_slot_nxt;
            done       <= (w_min_nxt == 7'd0) && (w_sec_nxt == 6'd0);
            an         <= w_an_nxt;
            dec_cat    <= w_cat_nxt;
        end
    end

endmodule

// File: tb/tb_mw_countdown_timer.sv
// Scoreboard bench for mw_countdown_timer (TICK_DIV=10, SCAN_DIV=4).
// Stimulus pushes the expected count per cycle; the monitor checks done,
// an and dec_cat at every negedge that has a queued expectation.
module tb_mw_countdown_timer;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [6:0] min;
    logic [6:0] sec;
    logic       done;
    logic [7:0] an;
    logic [7:0] dec_cat;

    typedef struct {
        int         cyc;
        logic       done;
        logic [7:0] an;
        logic [7:0] cat;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;
    int   cyc;
    int   checks;
    int   errors;

    mw_countdown_timer #(
        .TICK_DIV(10),
        .SCAN_DIV(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .min     (min),
        .sec     (sec),
        .done    (done),
        .an      (an),
        .dec_cat (dec_cat)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Rising edges since reset release; selects the expected scan slot
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [7:0] seg7(input int d);
        case (d)
            0: return 8'h03;
            1: return 8'h9F;
            2: return 8'h25;
            3: return 8'h0D;
            4: return 8'h99;
            5: return 8'h49;
            6: return 8'h41;
            7: return 8'h1F;
            8: return 8'h01;
            9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    // Queue the expected display/done for count mm:ss over cycles c0..c1
    task automatic exp_cnt(input int c0, input int c1, input int mm, input int ss, input string nm);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            int   k;
            k      = (c / 4) % 5;
            e.cyc  = c;
            e.done = (mm == 0 && ss == 0);
            e.nm   = nm;
            case (k)
                0: begin e.an = 8'hFE; e.cat = seg7(ss % 10); end
                1: begin e.an = 8'hFD; e.cat = seg7(ss / 10); end
                2: begin e.an = 8'hFB; e.cat = seg7(mm % 10) & 8'hFE; end
                3: begin e.an = 8'hF7; e.cat = seg7(mm / 10); end
                default: begin e.an = 8'hDF; e.cat = 8'hFF; end
            endcase
            q.push_back(e);
        end
    endtask

    // Drive a command for one cycle from a negedge; sampled at the next posedge
    task automatic cmd(input logic s, input logic p, input logic t, input int mm, input int ss);
        min   = 7'(mm);
        sec   = 7'(ss);
        start = s;
        pause = p;
        stop  = t;
        @(negedge clock);
        start = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            q.delete();
        end
    endtask

    // Monitor: compare every expectation due at this cycle
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_mon = q.pop_front();
            if (e_mon.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s missed: due cyc %0d, now %0d", e_mon.nm, e_mon.cyc, cyc);
            end else begin
                checks++;
                if (done !== e_mon.done) begin
                    errors++;
                    $display("FAIL %s done cyc %0d: got %b want %b", e_mon.nm, cyc, done, e_mon.done);
                end
                checks++;
                if (an !== e_mon.an) begin
                    errors++;
                    $display("FAIL %s an cyc %0d: got %h want %h", e_mon.nm, cyc, an, e_mon.an);
                end
                checks++;
                if (dec_cat !== e_mon.cat) begin
                    errors++;
                    $display("FAIL %s dec_cat cyc %0d: got %h want %h", e_mon.nm, cyc, dec_cat, e_mon.cat);
                end
            end
        end
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int L;
        int P;
        checks = 0;
        errors = 0;
        start  = 1'b0;
        stop   = 1'b0;
        pause  = 1'b0;
        min    = '0;
        sec    = '0;
        reset  = 1'b1;
        #1;
        exp_cnt(0, 0, 0, 0, "reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Idle scan: FE,FD,FB,F7,DF each 4 cycles, showing 00.00
        exp_cnt(1, 20, 0, 0, "scan_idle");
        drain();

        // 00:03 countdown to zero, then stays idle
        L = cyc + 1;
        exp_cnt(L,      L + 9,  0, 3, "run3_a");
        exp_cnt(L + 10, L + 19, 0, 2, "run3_b");
        exp_cnt(L + 20, L + 29, 0, 1, "run3_c");
        exp_cnt(L + 30, L + 45, 0, 0, "run3_end");
        cmd(1, 0, 0, 0, 3);
        drain();

        // 01:00 -> 00:59 borrow; start with new inputs during RUN ignored
        L = cyc + 1;
        exp_cnt(L,      L + 9,  1, 0,  "load_0100");
        exp_cnt(L + 10, L + 19, 0, 59, "borrow_0059");
        exp_cnt(L + 20, L + 24, 0, 58, "run_0058");
        exp_cnt(L + 25, L + 30, 0, 0,  "stop_run");
        cmd(1, 0, 0, 1, 0);
        goto(L + 2);
        cmd(1, 0, 0, 5, 5);
        goto(L + 24);
        cmd(0, 0, 1, 5, 5);
        drain();

        // Pause/resume timing; start resumes from PAUSED without reloading
        L = cyc + 1;
        P = L + 115;
        exp_cnt(L,      L + 9,  0, 5, "pz_load");
        exp_cnt(L + 10, P + 4,  0, 4, "pz_hold");
        exp_cnt(P + 5,  P + 14, 0, 3, "pz_resume");
        exp_cnt(P + 15, P + 37, 0, 2, "pz_start_resume");
        exp_cnt(P + 38, P + 44, 0, 1, "pz_after");
        exp_cnt(P + 45, P + 50, 0, 0, "pz_stop");
        cmd(1, 0, 0, 0, 5);
        goto(L + 14);
        cmd(0, 1, 0, 0, 5);
        goto(L + 114);
        cmd(0, 1, 0, 0, 5);
        goto(P + 16);
        cmd(0, 1, 0, 0, 5);
        goto(P + 29);
        cmd(1, 0, 0, 0, 9);
        goto(P + 39);
        cmd(0, 1, 0, 0, 9);
        goto(P + 44);
        cmd(0, 0, 1, 0, 9);
        drain();

        // start+pause+stop together in RUN: stop wins
        L = cyc + 1;
        exp_cnt(L,     L + 4,  0, 30, "all_pre");
        exp_cnt(L + 5, L + 20, 0, 0,  "all_cmds");
        cmd(1, 0, 0, 0, 30);
        goto(L + 4);
        cmd(1, 1, 1, 0, 30);
        drain();

        // Clamp 120:75 -> 99:59; zero load ignored
        L = cyc + 1;
        exp_cnt(L,      L + 9,  99, 59, "clamp_9959");
        exp_cnt(L + 10, L + 11, 99, 58, "clamp_dec");
        exp_cnt(L + 12, L + 40, 0,  0,  "zero_start");
        cmd(1, 0, 0, 120, 75);
        goto(L + 11);
        cmd(0, 0, 1, 0, 0);
        goto(L + 14);
        cmd(1, 0, 0, 0, 0);
        drain();

        // Clamp 100:00 -> 99:00, minute borrow to 98:59
        L = cyc + 1;
        exp_cnt(L,      L + 9,  99, 0,  "clamp_9900");
        exp_cnt(L + 10, L + 12, 98, 59, "borrow_9859");
        exp_cnt(L + 13, L + 15, 0,  0,  "stop_b");
        cmd(1, 0, 0, 100, 0);
        goto(L + 12);
        cmd(0, 0, 1, 0, 0);
        drain();

        // Seconds-only clamp 05:60 -> 05:59
        L = cyc + 1;
        exp_cnt(L,     L + 3, 5, 59, "clamp_0559");
        exp_cnt(L + 4, L + 6, 0, 0,  "stop_c");
        cmd(1, 0, 0, 5, 60);
        goto(L + 3);
        cmd(0, 0, 1, 0, 0);
        drain();

        // Asynchronous reset mid-countdown, then wait idle
        L = cyc + 1;
        exp_cnt(L, L + 7, 0, 20, "pre_reset");
        cmd(1, 0, 0, 0, 20);
        drain();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        exp_cnt(0, 0, 0, 0, "async_reset");
        repeat (3) @(negedge clock);
        reset = 1'b0;
        exp_cnt(1, 25, 0, 0, "after_reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
